// File: rtl/ram_stream_reader_if.sv
// rtl/ram_stream_reader_if.sv - command, RAM read port and output stream bundle for ram_stream_reader
//
// Signals:
//   cmd_valid/cmd_ready/cmd_addr/cmd_len : burst command handshake
//   ram_en/ram_addr/ram_rdata            : synchronous-read RAM port (1-cycle latency)
//   m_valid/m_ready/m_data/m_last        : output word stream
//   done                                 : one-cycle burst completion pulse
// Modports: slave = the reader block, master = the surrounding logic / bench.
interface ram_stream_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 11
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  ram_en;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic                  done;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, ram_rdata, m_ready,
        output cmd_ready, ram_en, ram_addr, m_valid, m_data, m_last, done
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_len, ram_rdata, m_ready,
        input  cmd_ready, ram_en, ram_addr, m_valid, m_data, m_last, done
    );
endinterface

// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - burst reader from a synchronous-read RAM port onto a valid/ready stream
//
// Ports:
//   clk   : single clock, also clocks the RAM port
//   rst_n : asynchronous active-low reset
//   bus   : ram_stream_reader_if.slave (command, RAM read port, output stream, done)
//
// A command (addr, len) is accepted in IDLE; ISSUE then reads len consecutive
// words (address wraps modulo 2^ADDR_WIDTH), only when the FIFO is guaranteed
// to have room for the returning word; DRAIN waits for the stream to empty
// and pulses done.
module ram_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 11,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_stream_reader_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic                  pend_q;
    logic                  pend_last_q;

    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    logic                  accept;
    logic                  issue;
    logic                  credit_ok;
    logic                  push;
    logic                  pop;
    logic [CW:0]           credit_need;

    // Occupancy plus in-flight read plus the read about to issue must fit.
    // A same-cycle pop is deliberately not credited; it frees space one cycle later.
    assign credit_need = {1'b0, count} + (CW+1)'(pend_q) + (CW+1)'(1);
    assign credit_ok   = (credit_need <= (CW+1)'(FIFO_DEPTH));

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        issue         = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                // Zero-length commands are consumed here without leaving IDLE.
                if (bus.cmd_valid && (bus.cmd_len != '0)) begin
                    accept  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                issue = credit_ok;
                if (credit_ok && (rem_q == LEN_WIDTH'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Empty FIFO with nothing in flight means the last beat has been taken.
                if ((count == '0) && !pend_q) begin
                    bus.done = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.ram_en   = issue;
    assign bus.ram_addr = addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= issue;
            pend_last_q <= issue && (rem_q == LEN_WIDTH'(1));
            if (accept) begin
                addr_q <= bus.cmd_addr;
                rem_q  <= bus.cmd_len;
            end else if (issue) begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
                rem_q  <= rem_q - LEN_WIDTH'(1);
            end
        end
    end

    // Read data is valid in the cycle after issue and is captured at the following edge.
    assign push = pend_q;
    assign pop  = bus.m_valid && bus.m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= bus.ram_rdata;
            fifo_last[wr_ptr] <= pend_last_q;
        end
    end

    // Head is gated so the stream outputs read as zero whenever nothing is valid.
    assign bus.m_valid = (count != '0);
    assign bus.m_data  = bus.m_valid ? fifo_data[rd_ptr] : '0;
    assign bus.m_last  = bus.m_valid ? fifo_last[rd_ptr] : 1'b0;
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb/tb_ram_stream_reader.sv - self-checking bench for ram_stream_reader
module tb_ram_stream_reader;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int LW = 11;
    localparam int FD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    ram_stream_reader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .FIFO_DEPTH(FD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [DW-1:0] mem [1024];
    always @(posedge clk) begin
        if (bus.ram_en) bus.ram_rdata <= mem[bus.ram_addr];
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [DW:0] exp_q [$];
    int          addr_log [$];
    int issued = 0, popped = 0, en_count = 0, beat_count = 0, last_count = 0, done_count = 0;
    int first_valid = -1, acc_cyc = -1, last_hs_cyc = -1, done_cyc = -1;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] data_prev  = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Observes one cycle at the falling edge: handshakes seen here complete at the next rising edge.
    task automatic monitor();
        logic [DW:0] e;
        if (!rst_n) begin
            stall_prev = 1'b0;
            return;
        end
        if (bus.ram_en) begin
            check("credit_space", 64'(issued - popped < FD), 64'(1));
            issued++;
            en_count++;
            addr_log.push_back(int'(bus.ram_addr));
        end
        if (stall_prev) check("stall_stable", 64'(bus.m_data), 64'(data_prev));
        if (bus.m_valid && first_valid < 0) first_valid = cyc;
        if (bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("beat_data", 64'(bus.m_data), 64'(e[DW-1:0]));
                check("beat_last", 64'(bus.m_last), 64'(e[DW]));
            end
            popped++;
            beat_count++;
            if (bus.m_last) begin
                last_count++;
                last_hs_cyc = cyc;
            end
        end
        if (bus.done) begin
            done_count++;
            done_cyc = cyc;
        end
        stall_prev = bus.m_valid && !bus.m_ready;
        data_prev  = bus.m_data;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int addr, input int len);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = AW'(addr);
        bus.cmd_len   = LW'(len);
        first_valid   = -1;
        last_hs_cyc   = -1;
        done_cyc      = -1;
        check("cmd_ready_idle", 64'(bus.cmd_ready), 64'(1));
        acc_cyc = cyc + 1;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({(i == len - 1), mem[(addr + i) % 1024]});
        end
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rand_ready);
        int d0 = done_count;
        int n  = 0;
        while (done_count == d0 && n < budget) begin
            if (rand_ready) bus.m_ready = 1'($urandom % 2);
            tick();
            n++;
        end
        check("done_seen", 64'(done_count - d0), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
        check({tag, "_ram_en"},    64'(bus.ram_en),    64'(0));
        check({tag, "_ram_addr"},  64'(bus.ram_addr),  64'(0));
        check({tag, "_m_valid"},   64'(bus.m_valid),   64'(0));
        check({tag, "_m_data"},    64'(bus.m_data),    64'(0));
        check({tag, "_m_last"},    64'(bus.m_last),    64'(0));
        check({tag, "_done"},      64'(bus.done),      64'(0));
    endtask

    initial begin
        int e0, b0, d0, l0, n, ra;
        for (int i = 0; i < 1024; i++) mem[i] = DW'(i + 'h100);
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.m_ready   = 1'b1;

        // Reset state
        repeat (3) tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // Basic burst: timing, consecutive beats, done and return to idle
        send_cmd(8, 5);
        wait_done(200, 1'b0);
        check("t1_first_valid_lat", 64'(first_valid - acc_cyc), 64'(3));
        check("t1_beat_span",       64'(last_hs_cyc - first_valid), 64'(4));
        check("t1_done_after_last", 64'(done_cyc - last_hs_cyc), 64'(1));
        check("t1_cmd_ready_after", 64'(bus.cmd_ready), 64'(1));
        check("t1_queue_empty",     64'(exp_q.size()), 64'(0));

        // Address wrap
        addr_log.delete();
        send_cmd(1022, 4);
        wait_done(200, 1'b0);
        check("t2_addr_count", 64'(addr_log.size()), 64'(4));
        if (addr_log.size() == 4) begin
            check("t2_addr0", 64'(addr_log[0]), 64'(1022));
            check("t2_addr1", 64'(addr_log[1]), 64'(1023));
            check("t2_addr2", 64'(addr_log[2]), 64'(0));
            check("t2_addr3", 64'(addr_log[3]), 64'(1));
        end

        // Backpressure: issue limited by credit while stalled
        bus.m_ready = 1'b0;
        e0 = en_count;
        b0 = beat_count;
        send_cmd(40, 8);
        repeat (10) tick();
        check("t3_stall_reads", 64'(en_count - e0), 64'(FD));
        check("t3_stall_beats", 64'(beat_count - b0), 64'(0));
        bus.m_ready = 1'b1;
        wait_done(200, 1'b0);
        check("t3_beats",    64'(beat_count - b0), 64'(8));
        check("t3_reads",    64'(en_count - e0), 64'(8));

        // Long burst under random backpressure at a random base
        b0 = beat_count;
        l0 = last_count;
        d0 = done_count;
        ra = int'($urandom_range(0, 1023));
        send_cmd(ra, 100);
        wait_done(2000, 1'b1);
        bus.m_ready = 1'b1;
        repeat (3) tick();
        check("t4_beats", 64'(beat_count - b0), 64'(100));
        check("t4_lasts", 64'(last_count - l0), 64'(1));
        check("t4_dones", 64'(done_count - d0), 64'(1));
        check("t4_queue_empty", 64'(exp_q.size()), 64'(0));

        // Zero-length command is a no-op, then a normal one
        e0 = en_count;
        b0 = beat_count;
        d0 = done_count;
        send_cmd(300, 0);
        for (int i = 0; i < 5; i++) begin
            check("t5_cmd_ready", 64'(bus.cmd_ready), 64'(1));
            tick();
        end
        check("t5_no_reads", 64'(en_count - e0), 64'(0));
        check("t5_no_beats", 64'(beat_count - b0), 64'(0));
        check("t5_no_done",  64'(done_count - d0), 64'(0));
        send_cmd(500, 2);
        wait_done(200, 1'b0);
        check("t5_follow_beats", 64'(beat_count - b0), 64'(2));

        // Asynchronous reset mid-burst
        b0 = beat_count;
        send_cmd(32, 10);
        n = 0;
        while (beat_count - b0 < 3 && n < 100) begin
            tick();
            n++;
        end
        check("t6_three_beats", 64'(beat_count - b0), 64'(3));
        d0 = done_count;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_midrst");
        exp_q.delete();
        issued = 0;
        popped = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("t6_no_done", 64'(done_count - d0), 64'(0));
        b0 = beat_count;
        send_cmd(0, 2);
        wait_done(200, 1'b0);
        check("t6_post_beats", 64'(beat_count - b0), 64'(2));
        check("t6_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
